// File: rtl/rename_pkg.sv
// Rename register file: shared defaults, index/tag types, snapshot layout.
// Optional checkpoint ring is enabled with RENAME_CKPT_EN.
package rename_pkg;
  localparam int XLEN_D  = 32;
  localparam int NREG_D  = 32;
  localparam int TW_D    = 4;
  localparam int NRP_D   = 2;
  localparam int NCKPT_D = 4;
  localparam int RW_D    = $clog2(NREG_D);
  localparam int CKW_D   = $clog2(NCKPT_D);

  typedef logic [TW_D-1:0]  tag_t;
  typedef logic [RW_D-1:0]  reg_idx_t;
  typedef logic [CKW_D-1:0] ckpt_id_t;

  typedef struct packed {
    logic [NREG_D-1:0]           b;
    logic [NREG_D-1:0][TW_D-1:0] q;
  } snap_t;

  // Flattened snapshot width: one busy bit plus one tag per register.
  function automatic int snap_w(input int nreg, input int tw);
    return nreg * (tw + 1);
  endfunction
endpackage

// File: rtl/rename_ckpt_ring.sv
// Checkpoint ring: snapshot storage with head/tail/count bookkeeping.
// Used by rename_regfile when RENAME_CKPT_EN is defined.
module rename_ckpt_ring #(
  parameter int NCKPT = 4,
  parameter int SW    = 160,
  localparam int CKW  = $clog2(NCKPT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clr,
  input  logic           save,
  input  logic           restore,
  input  logic [CKW-1:0] restore_id,
  input  logic           free,
  input  logic [SW-1:0]  snap_i,
  output logic [SW-1:0]  snap_o,
  output logic [CKW-1:0] id_o,
  output logic           full_o
);
  localparam logic [CKW-1:0] C_ONE  = CKW'(1);
  localparam logic [CKW:0]   C_ONEW = (CKW+1)'(1);
  localparam logic [CKW:0]   C_FULL = (CKW+1)'(NCKPT);

  logic [CKW-1:0] head_q, head_d;
  logic [CKW-1:0] tail_q, tail_d;
  logic [CKW:0]   cnt_q, cnt_d;
  logic [CKW-1:0] span;
  logic [SW-1:0]  mem_q [NCKPT];
  logic           do_save;
  logic           do_free;

  assign full_o  = (cnt_q == C_FULL);
  assign id_o    = tail_q;
  assign snap_o  = mem_q[restore_id];
  assign do_free = free && (cnt_q != '0);
  assign do_save = save && !full_o && !restore && !clr;

  // Next head/tail/count; a restore drops every slot younger than restore_id.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    span   = '0;
    if (clr) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (restore) begin
      if (do_free) head_d = head_q + C_ONE;
      tail_d = restore_id + C_ONE;
      span   = restore_id - head_d;
      cnt_d  = {1'b0, span} + C_ONEW;
    end else begin
      if (do_save) tail_d = tail_q + C_ONE;
      if (do_free) head_d = head_q + C_ONE;
      cnt_d = cnt_q + (CKW+1)'(do_save) - (CKW+1)'(do_free);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (en) begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Snapshot storage, written at the tail slot.
  always_ff @(posedge clk) begin
    if (!rst && en && do_save) mem_q[tail_q] <= snap_i;
  end
endmodule

// File: rtl/rename_regfile.sv
// Register file with rename state (value, busy, ROB tag) per register.
// Define RENAME_CKPT_EN to add the checkpoint ring and its ports.
module rename_regfile
  import rename_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREG  = NREG_D,
  parameter int TW    = TW_D,
  parameter int NRP   = NRP_D,
  parameter int NCKPT = NCKPT_D,
  localparam int RW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic [NRP-1:0]      rd_en,
  input  logic [NRP*RW-1:0]   rd_addr,
  output logic [NRP-1:0]      rd_ready,
  output logic [NRP*XLEN-1:0] rd_data,
  input  logic                disp_en,
  input  logic [RW-1:0]       disp_rd,
  input  logic [TW-1:0]       disp_tag,
  input  logic                cm_en,
  input  logic [RW-1:0]       cm_rd,
  input  logic [TW-1:0]       cm_tag,
  input  logic [XLEN-1:0]     cm_data
`ifdef RENAME_CKPT_EN
  ,
  input  logic                       ck_save,
  output logic [$clog2(NCKPT)-1:0]   ck_id,
  output logic                       ck_full,
  input  logic                       ck_restore,
  input  logic [$clog2(NCKPT)-1:0]   ck_restore_id,
  input  logic                       ck_free
`endif
);
  if ((NCKPT & (NCKPT - 1)) != 0) begin : g_bad_nckpt
    $error("NCKPT must be a power of two");
  end

  logic [NREG-1:0][XLEN-1:0] v_q, v_n, v_d;
  logic [NREG-1:0]           b_q, b_n, b_d;
  logic [NREG-1:0][TW-1:0]   q_q, q_n, q_d;
  logic                      cm_wr;
  logic                      dp_wr;

  assign cm_wr = cm_en && (cm_rd != '0);
  assign dp_wr = disp_en && (disp_rd != '0);

  // Normal update: commit writes value, dispatch renames (dispatch wins B/Q).
  always_comb begin
    v_n = v_q;
    b_n = b_q;
    q_n = q_q;
    if (cm_wr) begin
      v_n[cm_rd] = cm_data;
      if (q_q[cm_rd] == cm_tag) b_n[cm_rd] = 1'b0;
    end
    if (dp_wr) begin
      q_n[disp_rd] = disp_tag;
      b_n[disp_rd] = 1'b1;
    end
  end

`ifdef RENAME_CKPT_EN
  localparam int SW = snap_w(NREG, TW);

  logic [SW-1:0]           snap_w_s;
  logic [SW-1:0]           snap_r_s;
  logic [NREG-1:0]         rs_b;
  logic [NREG-1:0][TW-1:0] rs_q;

  // Pack next-state B/Q for saving and unpack the restored slot.
  always_comb begin
    snap_w_s = '0;
    rs_b     = '0;
    rs_q     = '0;
    for (int r = 0; r < NREG; r++) begin
      snap_w_s[r*(TW+1) +: TW+1] = {b_n[r], q_n[r]};
      rs_b[r] = snap_r_s[r*(TW+1)+TW];
      rs_q[r] = snap_r_s[r*(TW+1) +: TW];
    end
  end

  rename_ckpt_ring #(
    .NCKPT(NCKPT),
    .SW   (SW)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .en        (rdy),
    .clr       (flush),
    .save      (ck_save),
    .restore   (ck_restore),
    .restore_id(ck_restore_id),
    .free      (ck_free),
    .snap_i    (snap_w_s),
    .snap_o    (snap_r_s),
    .id_o      (ck_id),
    .full_o    (ck_full)
  );
`endif

  // Recovery overrides: flush clears busy, restore reloads B/Q.
  always_comb begin
    v_d = v_n;
    b_d = b_n;
    q_d = q_n;
    if (flush) begin
      b_d = '0;
      q_d = q_q;
    end
`ifdef RENAME_CKPT_EN
    else if (ck_restore) begin
      for (int r = 0; r < NREG; r++) begin
        q_d[r] = rs_q[r];
        b_d[r] = rs_b[r] && !(cm_en && (rs_q[r] == cm_tag));
      end
      b_d[0] = 1'b0;
      q_d[0] = '0;
    end
`endif
  end

  // State registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      b_q <= '0;
      q_q <= '0;
    end else if (rdy) begin
      v_q <= v_d;
      b_q <= b_d;
      q_q <= q_d;
    end
  end

  // Operand reads with same-cycle commit bypass.
  always_comb begin
    logic [RW-1:0] a;
    a        = '0;
    rd_ready = '0;
    rd_data  = '0;
    for (int p = 0; p < NRP; p++) begin
      a = rd_addr[p*RW +: RW];
      if (rd_en[p]) begin
        if (!b_q[a]) begin
          rd_ready[p]              = 1'b1;
          rd_data[p*XLEN +: XLEN] = v_q[a];
        end else if (cm_en && (cm_tag == q_q[a])) begin
          rd_ready[p]              = 1'b1;
          rd_data[p*XLEN +: XLEN] = cm_data;
        end else begin
          rd_data[p*XLEN +: XLEN] = XLEN'(q_q[a]);
        end
      end
    end
  end
endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile (default parameters).
// Checkpoint sequences run only when RENAME_CKPT_EN is defined.
module tb_rename_regfile;
  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_ready;
  logic [63:0] rd_data;
  logic        disp_en;
  logic [4:0]  disp_rd;
  logic [3:0]  disp_tag;
  logic        cm_en;
  logic [4:0]  cm_rd;
  logic [3:0]  cm_tag;
  logic [31:0] cm_data;
`ifdef RENAME_CKPT_EN
  logic        ck_save;
  logic [1:0]  ck_id;
  logic        ck_full;
  logic        ck_restore;
  logic [1:0]  ck_restore_id;
  logic        ck_free;
`endif

  int n_cmp;
  int n_bad;

  rename_regfile dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .flush   (flush),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .disp_en (disp_en),
    .disp_rd (disp_rd),
    .disp_tag(disp_tag),
    .cm_en   (cm_en),
    .cm_rd   (cm_rd),
    .cm_tag  (cm_tag),
    .cm_data (cm_data)
`ifdef RENAME_CKPT_EN
    ,
    .ck_save      (ck_save),
    .ck_id        (ck_id),
    .ck_full      (ck_full),
    .ck_restore   (ck_restore),
    .ck_restore_id(ck_restore_id),
    .ck_free      (ck_free)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        fl;
    logic        de;
    logic [4:0]  dr;
    logic [3:0]  dt;
    logic        ce;
    logic [4:0]  cr;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  er;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  typedef struct packed {
    logic [7:0]  row;
    logic [0:0]  port;
    logic        r;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[27];

  task automatic idle();
    rdy     = 1'b1;
    flush   = 1'b0;
    rd_en   = '0;
    rd_addr = '0;
    disp_en = 1'b0;
    disp_rd = '0;
    disp_tag = '0;
    cm_en   = 1'b0;
    cm_rd   = '0;
    cm_tag  = '0;
    cm_data = '0;
`ifdef RENAME_CKPT_EN
    ck_save       = 1'b0;
    ck_restore    = 1'b0;
    ck_restore_id = '0;
    ck_free       = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, queue expectations, then compare reads.
  task automatic drive_chk(input int row, input vec_t v);
    exp_t e;
    rdy      = v.rdy;
    flush    = v.fl;
    disp_en  = v.de;
    disp_rd  = v.dr;
    disp_tag = v.dt;
    cm_en    = v.ce;
    cm_rd    = v.cr;
    cm_tag   = v.ct;
    cm_data  = v.cd;
    rd_en    = v.en;
    rd_addr  = {v.a1, v.a0};
    sb.push_back({8'(row), 1'b0, v.er[0], v.e0});
    sb.push_back({8'(row), 1'b1, v.er[1], v.e1});
    #2;
    while (sb.size() > 0) begin
      logic        ar;
      logic [31:0] ad;
      e  = sb.pop_front();
      ar = rd_ready[e.port];
      ad = e.port ? rd_data[63:32] : rd_data[31:0];
      n_cmp++;
      if (ar !== e.r || ad !== e.d) begin
        n_bad++;
        $display("FAIL row %0d port %0d: got ready=%0b data=%h want ready=%0b data=%h",
                 e.row, e.port, ar, ad, e.r, e.d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // rdy fl de dr dt ce cr ct cd en a0 a1 er e0 e1
    tbl[0]  = '{1,0,0,0,0,0,0,0,0,2'b11,0,3,2'b11,0,0};
    tbl[1]  = '{1,0,0,0,0,0,0,0,0,2'b00,3,3,2'b00,0,0};
    tbl[2]  = '{1,0,1,5,3,0,0,0,0,2'b01,5,0,2'b01,0,0};
    tbl[3]  = '{1,0,0,0,0,0,0,0,0,2'b11,5,5,2'b00,3,3};
    tbl[4]  = '{1,0,0,0,0,1,5,3,32'hDEAD,2'b01,2,0,2'b01,0,0};
    tbl[5]  = '{1,0,0,0,0,0,0,0,0,2'b01,5,0,2'b01,32'hDEAD,0};
    tbl[6]  = '{1,0,1,5,3,0,0,0,0,2'b01,5,0,2'b01,32'hDEAD,0};
    tbl[7]  = '{1,0,0,0,0,1,5,3,7,2'b11,5,5,2'b11,7,7};
    tbl[8]  = '{1,0,0,0,0,0,0,0,0,2'b01,5,0,2'b01,7,0};
    tbl[9]  = '{1,0,1,5,3,0,0,0,0,2'b01,6,0,2'b01,0,0};
    tbl[10] = '{1,0,1,5,6,0,0,0,0,2'b01,5,0,2'b00,3,0};
    tbl[11] = '{1,0,0,0,0,1,5,3,32'h11,2'b01,5,0,2'b00,6,0};
    tbl[12] = '{1,0,0,0,0,0,0,0,0,2'b01,5,0,2'b00,6,0};
    tbl[13] = '{1,0,0,0,0,1,5,6,32'h22,2'b01,5,0,2'b01,32'h22,0};
    tbl[14] = '{1,0,0,0,0,0,0,0,0,2'b01,5,0,2'b01,32'h22,0};
    tbl[15] = '{1,0,0,0,0,1,0,0,32'hFF,2'b01,0,0,2'b01,0,0};
    tbl[16] = '{1,0,0,0,0,0,0,0,0,2'b11,0,5,2'b11,0,32'h22};
    tbl[17] = '{1,0,1,9,4,1,9,2,32'h33,2'b01,9,0,2'b01,0,0};
    tbl[18] = '{1,0,0,0,0,0,0,0,0,2'b01,9,0,2'b00,4,0};
    tbl[19] = '{1,0,0,0,0,1,9,4,32'h44,2'b01,9,0,2'b01,32'h44,0};
    tbl[20] = '{1,0,1,1,5,0,0,0,0,2'b01,1,0,2'b01,0,0};
    tbl[21] = '{1,0,1,2,7,0,0,0,0,2'b11,1,2,2'b10,5,0};
    tbl[22] = '{1,1,1,3,8,1,1,0,32'h55,2'b11,1,2,2'b00,5,7};
    tbl[23] = '{1,0,0,0,0,0,0,0,0,2'b11,1,2,2'b11,32'h55,0};
    tbl[24] = '{1,0,0,0,0,0,0,0,0,2'b11,3,9,2'b11,0,32'h44};
    tbl[25] = '{0,0,1,4,1,1,9,4,32'h99,2'b11,4,9,2'b11,0,32'h44};
    tbl[26] = '{1,0,0,0,0,0,0,0,0,2'b11,4,9,2'b11,0,32'h44};

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
`ifdef RENAME_CKPT_EN
    #2;
    chk("reset ck_full", int'(ck_full), 0);
    chk("reset ck_id", int'(ck_id), 0);
`endif
    for (int i = 0; i < 27; i++) begin
      drive_chk(i, tbl[i]);
      tick();
    end

`ifdef RENAME_CKPT_EN
    // Save, rename x7, restore: x7 returns to its old committed value.
    drive_chk(100, '{1,0,0,0,0,1,7,15,32'h77,2'b00,0,0,2'b00,0,0});
    tick();
    ck_save = 1'b1;
    drive_chk(101, '{1,0,0,0,0,0,0,0,0,2'b01,7,0,2'b01,32'h77,0});
    chk("save ck_id", int'(ck_id), 0);
    tick();
    drive_chk(102, '{1,0,1,7,9,0,0,0,0,2'b00,0,0,2'b00,0,0});
    chk("after save ck_id", int'(ck_id), 1);
    tick();
    drive_chk(103, '{1,0,0,0,0,0,0,0,0,2'b01,7,0,2'b00,9,0});
    tick();
    ck_restore    = 1'b1;
    ck_restore_id = 2'd0;
    drive_chk(104, '{1,0,0,0,0,0,0,0,0,2'b01,7,0,2'b00,9,0});
    tick();
    drive_chk(105, '{1,0,0,0,0,0,0,0,0,2'b01,7,0,2'b01,32'h77,0});
    chk("restore tail", int'(ck_id), 1);
    tick();

    // Restore alongside a commit of the restored tag clears busy.
    flush = 1'b1;
    drive_chk(110, '{1,1,0,0,0,0,0,0,0,2'b00,0,0,2'b00,0,0});
    tick();
    chk("flush ck_id", int'(ck_id), 0);
    chk("flush ck_full", int'(ck_full), 0);
    ck_save = 1'b1;
    drive_chk(111, '{1,0,1,8,10,0,0,0,0,2'b00,0,0,2'b00,0,0});
    tick();
    drive_chk(112, '{1,0,1,8,11,0,0,0,0,2'b01,8,0,2'b00,10,0});
    tick();
    ck_restore    = 1'b1;
    ck_restore_id = 2'd0;
    drive_chk(113, '{1,0,0,0,0,1,8,10,32'h88,2'b01,8,0,2'b00,11,0});
    tick();
    drive_chk(114, '{1,0,0,0,0,0,0,0,0,2'b01,8,0,2'b01,32'h88,0});
    tick();

    // Fill the ring, overflow, free one, wrap the tail.
    flush = 1'b1;
    drive_chk(120, '{1,1,0,0,0,0,0,0,0,2'b00,0,0,2'b00,0,0});
    tick();
    for (int s = 0; s < 4; s++) begin
      ck_save = 1'b1;
      #2;
      chk("fill ck_id", int'(ck_id), s);
      chk("fill ck_full", int'(ck_full), 0);
      tick();
    end
    #2;
    chk("full flag", int'(ck_full), 1);
    ck_save = 1'b1;
    tick();
    #2;
    chk("overflow ck_id", int'(ck_id), 0);
    chk("overflow full", int'(ck_full), 1);
    ck_free = 1'b1;
    tick();
    #2;
    chk("free full", int'(ck_full), 0);
    ck_save = 1'b1;
    #2;
    chk("wrap ck_id", int'(ck_id), 0);
    tick();
    #2;
    chk("refill full", int'(ck_full), 1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
